// File: rtl/bus_txn_pkg.sv
// bus_txn_pkg: transaction record and bus widths shared by the viewer blocks.
package bus_txn_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;
endpackage

// File: rtl/debouncer.sv
// debouncer: 2-flop synchronizer, stable-level counter and registered rising-edge pulse.
module debouncer #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, prev_q, rise_q;
    logic          differ, done;

    // The level flips on the CYCLES-th consecutive disagreeing sample.
    assign differ = sync_q[1] != level_q;
    assign done   = differ && cnt_q == CW'(CYCLES - 1);

    always_comb begin
        cnt_d   = (differ && !done) ? cnt_q + 1'b1 : '0;
        level_d = done ? ~level_q : level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], in};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            rise_q  <= level_q & ~prev_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/bus_txn_viewer.sv
// bus_txn_viewer: history FIFO of bus-tap transactions, stepped onto the display by a debounced button.
module bus_txn_viewer
    import bus_txn_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bus_valid,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_data,
    input  logic                     bus_rw,
    input  logic                     btn,
    output logic [ADDR_W+DATA_W-1:0] disp_val,
    output logic                     disp_rw,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);

    txn_t          mem [DEPTH];
    txn_t          disp_q, disp_d, wr_txn;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          press, full, pop, overwrite, level_unused;

    debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn),
        .level (level_unused),
        .rise  (press)
    );

    // A pop in the same cycle frees the slot, so only an unmatched push into a full FIFO overwrites.
    always_comb begin
        full      = count_q == (PW + 1)'(DEPTH);
        pop       = press && count_q != '0;
        overwrite = bus_valid && full && !pop;
        wr_txn    = '{rw: bus_rw, addr: bus_addr, data: bus_data};
        wr_ptr_d  = bus_valid ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = (pop || overwrite) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = (bus_valid && !pop && !full) ? count_q + 1'b1 :
                    (pop && !bus_valid) ? count_q - 1'b1 : count_q;
        ovf_d     = ovf_q || overwrite;
        disp_d    = pop ? mem[rd_ptr_q] : disp_q;
    end

    always_ff @(posedge clk) begin
        if (bus_valid) mem[wr_ptr_q] <= wr_txn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            disp_q   <= disp_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign disp_val = {disp_q.addr, disp_q.data};
    assign disp_rw  = disp_q.rw;
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule
